// File: rtl/registers_bank_mp_if.sv
// Bus bundle for registers_bank_mp: write/read ports, scoreboard issue,
// scoreboard status and the dump stream. Clock and reset are carried separately.
interface registers_bank_mp_if #(
  parameter int unsigned REGISTERS_BANK_SIZE = 32,
  parameter int unsigned REGISTERS_SIZE      = 32,
  parameter int unsigned READ_PORTS          = 2
);
  localparam int unsigned AW = $clog2(REGISTERS_BANK_SIZE);

  logic [1:0]                         i_wr_en;
  logic [2*AW-1:0]                    i_wr_addr;
  logic [2*REGISTERS_SIZE-1:0]        i_wr_data;
  logic [READ_PORTS*AW-1:0]           i_rd_addr;
  logic [READ_PORTS*REGISTERS_SIZE-1:0] o_rd_data;
  logic                               i_issue_en;
  logic [AW-1:0]                      i_issue_addr;
  logic [REGISTERS_BANK_SIZE-1:0]     o_busy;
  logic                               i_dump_start;
  logic                               i_dump_ready;
  logic                               o_dump_valid;
  logic [AW-1:0]                      o_dump_addr;
  logic [REGISTERS_SIZE-1:0]          o_dump_data;
  logic                               o_dump_done;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
    output i_issue_en, i_issue_addr, i_dump_start, i_dump_ready,
    input  o_rd_data, o_busy, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
    input  i_issue_en, i_issue_addr, i_dump_start, i_dump_ready,
    output o_rd_data, o_busy, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
  );
endinterface

// File: rtl/registers_bank_mp.sv
// Multi-port register bank: two write ports (port 1 wins on collision),
// READ_PORTS combinational read ports, register 0 hard-wired to zero,
// a per-register pending scoreboard and a ready/valid sequential dump engine.
// Optional feature: define REGISTERS_BANK_MP_BYPASS_EN to forward same-cycle
// write data to the read ports (dump data is never forwarded).
module registers_bank_mp #(
  parameter int unsigned REGISTERS_BANK_SIZE = 32,
  parameter int unsigned REGISTERS_SIZE      = 32,
  parameter int unsigned READ_PORTS          = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  registers_bank_mp_if.slave bus
);
  localparam int unsigned   AW       = $clog2(REGISTERS_BANK_SIZE);
  localparam int unsigned   DW       = REGISTERS_SIZE;
  localparam logic [AW-1:0] LAST_IDX = AW'(REGISTERS_BANK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    DONE
  } dump_state_e;

  logic [DW-1:0]                  regs_q [REGISTERS_BANK_SIZE];
  logic [DW-1:0]                  regs_d [REGISTERS_BANK_SIZE];
  logic [REGISTERS_BANK_SIZE-1:0] busy_q, busy_d;
  dump_state_e                    state_q, state_d;
  logic [AW-1:0]                  idx_q, idx_d;
  logic                           dump_valid_q, dump_valid_d;
  logic                           dump_done_q, dump_done_d;

  logic [AW-1:0]                  wr_addr [2];
  logic [DW-1:0]                  wr_data [2];
  logic [1:0]                     wr_hit;
  logic [AW-1:0]                  rd_addr [READ_PORTS];
  logic [DW-1:0]                  rd_word [READ_PORTS];

  // Unpack write ports; a hit is an enabled write to a nonzero address
  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      wr_addr[k] = bus.i_wr_addr[k*AW +: AW];
      wr_data[k] = bus.i_wr_data[k*DW +: DW];
      wr_hit[k]  = bus.i_wr_en[k] && (wr_addr[k] != '0);
    end
  end

  // Next register contents: port 1 applied last so it wins on collision
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (wr_hit[k]) begin
        regs_d[wr_addr[k]] = wr_data[k];
      end
    end
    regs_d[0] = '0;
  end

  // Scoreboard: writes clear first, then an issue sets, so issue wins
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (bus.i_wr_en[k]) begin
        busy_d[wr_addr[k]] = 1'b0;
      end
    end
    if (bus.i_issue_en) begin
      busy_d[bus.i_issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Combinational read ports, optionally forwarding same-cycle write data
  always_comb begin
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rd_addr[p] = bus.i_rd_addr[p*AW +: AW];
      rd_word[p] = (rd_addr[p] == '0) ? '0 : regs_q[rd_addr[p]];
`ifdef REGISTERS_BANK_MP_BYPASS_EN
      for (int unsigned k = 0; k < 2; k++) begin
        if (wr_hit[k] && (wr_addr[k] == rd_addr[p])) begin
          rd_word[p] = wr_data[k];
        end
      end
`endif
    end
  end

  // Pack read data onto the bus
  always_comb begin
    bus.o_rd_data = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      bus.o_rd_data[p*DW +: DW] = rd_word[p];
    end
  end

  // Dump FSM next state; valid/done are registered from the next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_dump_start) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      DUMP: begin
        if (bus.i_dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dump_valid_d = (state_d == DUMP);
    dump_done_d  = (state_d == DONE);
  end

  // Register storage
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < REGISTERS_BANK_SIZE; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Scoreboard and dump FSM state
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      busy_q       <= '0;
      state_q      <= IDLE;
      idx_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      dump_valid_q <= dump_valid_d;
      dump_done_q  <= dump_done_d;
    end
  end

  // Output drive; dump data always reflects stored contents
  always_comb begin
    bus.o_busy       = busy_q;
    bus.o_dump_valid = dump_valid_q;
    bus.o_dump_done  = dump_done_q;
    bus.o_dump_addr  = idx_q;
    bus.o_dump_data  = (idx_q == '0) ? '0 : regs_q[idx_q];
  end

endmodule

// File: tb/tb_registers_bank_mp.sv
// Directed testbench for registers_bank_mp with hand-computed expectations.
module tb_registers_bank_mp;
  localparam int unsigned N  = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RP = 2;
  localparam int unsigned AW = 5;
`ifdef REGISTERS_BANK_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  registers_bank_mp_if #(
    .REGISTERS_BANK_SIZE(N),
    .REGISTERS_SIZE(DW),
    .READ_PORTS(RP)
  ) bus ();

  registers_bank_mp #(
    .REGISTERS_BANK_SIZE(N),
    .REGISTERS_SIZE(DW),
    .READ_PORTS(RP)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_wr_en[k]              = 1'b1;
    bus.i_wr_addr[k*AW +: AW]   = a;
    bus.i_wr_data[k*DW +: DW]   = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    bus.i_rd_addr[p*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned exp_idx;
    int unsigned guard;
    bit          rdy;

    rst_n            = 1'b0;
    bus.i_wr_en      = '0;
    bus.i_wr_addr    = '0;
    bus.i_wr_data    = '0;
    bus.i_rd_addr    = '0;
    bus.i_issue_en   = 1'b0;
    bus.i_issue_addr = '0;
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;

    // Reset state
    tick();
    tick();
    rd(0, 5); rd(1, 31);
    #1;
    check("rst_busy", bus.o_busy, 0);
    check("rst_valid", bus.o_dump_valid, 0);
    check("rst_done", bus.o_dump_done, 0);
    check("rst_rd5", bus.o_rd_data[DW-1:0], 0);
    check("rst_rd31", bus.o_rd_data[2*DW-1:DW], 0);
    rst_n = 1'b1;

    // Basic write/read and register 0
    wr(0, 5, 32'hDEADBEEF); rd(1, 5);
    #1;
    check("rd5_same_cycle", bus.o_rd_data[2*DW-1:DW], BYP ? 64'hDEADBEEF : 64'h0);
    tick();
    bus.i_wr_en = '0;
    #1;
    check("rd5_after", bus.o_rd_data[2*DW-1:DW], 64'hDEADBEEF);
    wr(1, 0, 32'h1234); rd(0, 0);
    #1;
    check("rd0_same_cycle", bus.o_rd_data[DW-1:0], 0);
    tick();
    bus.i_wr_en = '0;
    #1;
    check("rd0_after", bus.o_rd_data[DW-1:0], 0);

    // Write collision: port 1 wins
    wr(0, 7, 32'h55);
    tick();
    bus.i_wr_en = '0;
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7);
    #1;
    check("rd7_collide_same", bus.o_rd_data[DW-1:0], BYP ? 64'h22 : 64'h55);
    tick();
    bus.i_wr_en = '0;
    #1;
    check("rd7_collide_after", bus.o_rd_data[DW-1:0], 64'h22);
    wr(0, 6, 32'h66); rd(1, 6);
    #1;
    check("rd6_p0_same", bus.o_rd_data[2*DW-1:DW], BYP ? 64'h66 : 64'h0);
    tick();
    bus.i_wr_en = '0;

    // Scoreboard
    bus.i_issue_en = 1'b1; bus.i_issue_addr = 3;
    tick();
    bus.i_issue_en = 1'b0;
    check("busy_issue3", bus.o_busy, 32'h8);
    wr(1, 3, 32'h33);
    tick();
    bus.i_wr_en = '0;
    check("busy_clear3", bus.o_busy, 0);
    bus.i_issue_en = 1'b1; bus.i_issue_addr = 9; wr(0, 9, 32'h99);
    tick();
    bus.i_issue_en = 1'b0; bus.i_wr_en = '0;
    check("busy_issue_wr9", bus.o_busy, 32'h200);
    bus.i_issue_en = 1'b1; bus.i_issue_addr = 0;
    tick();
    bus.i_issue_en = 1'b0;
    check("busy_issue0", bus.o_busy, 32'h200);
    wr(0, 9, 32'h99);
    tick();
    bus.i_wr_en = '0;
    check("busy_clear9_p0", bus.o_busy, 0);

    // Preload reg[i] = i*3
    for (int i = 1; i < 32; i += 2) begin
      bus.i_wr_en = '0;
      wr(0, AW'(i), DW'(i * 3));
      if (i + 1 < 32) wr(1, AW'(i + 1), DW'((i + 1) * 3));
      tick();
    end
    bus.i_wr_en = '0;
    rd(0, 31); rd(1, 30);
    #1;
    check("preload31", bus.o_rd_data[DW-1:0], 93);
    check("preload30", bus.o_rd_data[2*DW-1:DW], 90);

    // Full dump with toggling ready
    bus.i_dump_start = 1'b1; bus.i_dump_ready = 1'b0;
    tick();
    bus.i_dump_start = 1'b0;
    exp_idx = 0; rdy = 1'b1; guard = 0;
    while (exp_idx < N && guard < 200) begin
      bus.i_dump_ready = rdy;
      bus.i_dump_start = (exp_idx == 16);
      bus.i_issue_en   = (exp_idx == 5) && rdy;
      bus.i_issue_addr = 4;
      #1;
      check("dump_valid", bus.o_dump_valid, 1);
      check("dump_addr", bus.o_dump_addr, exp_idx);
      check("dump_data", bus.o_dump_data, exp_idx * 3);
      check("dump_done_early", bus.o_dump_done, 0);
      tick();
      if (rdy) exp_idx++;
      rdy = !rdy;
      guard++;
    end
    bus.i_dump_start = 1'b0; bus.i_issue_en = 1'b0; bus.i_dump_ready = 1'b0;
    check("dump_words", exp_idx, N);
    check("dump_done_pulse", bus.o_dump_done, 1);
    check("dump_done_valid", bus.o_dump_valid, 0);
    tick();
    check("dump_idle_done", bus.o_dump_done, 0);
    check("dump_idle_valid", bus.o_dump_valid, 0);
    check("busy_issue_in_dump", bus.o_busy, 32'h10);

    // Reset in the middle of a dump
    bus.i_dump_ready = 1'b1; bus.i_dump_start = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    guard = 0;
    while (bus.o_dump_addr != 10 && guard < 100) begin
      tick();
      guard++;
    end
    check("dump_reach10", bus.o_dump_addr, 10);
    rst_n = 1'b0;
    wr(0, 12, 32'hAA);
    bus.i_issue_en = 1'b1; bus.i_issue_addr = 12;
    tick();
    bus.i_wr_en = '0; bus.i_issue_en = 1'b0;
    rd(0, 6); rd(1, 12);
    #1;
    check("rstmid_valid", bus.o_dump_valid, 0);
    check("rstmid_done", bus.o_dump_done, 0);
    check("rstmid_busy", bus.o_busy, 0);
    check("rstmid_rd6", bus.o_rd_data[DW-1:0], 0);
    check("rstmid_rd12", bus.o_rd_data[2*DW-1:DW], 0);
    check("rstmid_addr", bus.o_dump_addr, 0);
    tick();
    check("rstmid_done2", bus.o_dump_done, 0);
    rst_n = 1'b1;
    tick();
    check("rstrel_done", bus.o_dump_done, 0);
    check("rstrel_valid", bus.o_dump_valid, 0);
    bus.i_dump_start = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    check("restart_valid", bus.o_dump_valid, 1);
    check("restart_addr", bus.o_dump_addr, 0);
    check("restart_data", bus.o_dump_data, 0);
    tick();
    check("restart_addr1", bus.o_dump_addr, 1);
    check("restart_data1", bus.o_dump_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
